// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 4;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } div_state_t;

endpackage

// File: rtl/subtraction.sv
// Combinational ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
module subtraction #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  logic br;

  always_comb begin
    diff = '0;
    br   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ b[i] ^ br;
      br      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    borrow_out = br;
  end

endmodule

// File: rtl/division.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/done handshake.
module division
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             diff_msb_unused;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign trial = {r_q, q_q[WIDTH-1]};

  subtraction #(
    .WIDTH(WIDTH + 1)
  ) u_sub (
    .a         (trial),
    .b         ({1'b0, dvs_q}),
    .diff      (diff),
    .borrow_out(borrow)
  );

  // With r < divisor the successful difference always fits in WIDTH bits.
  assign diff_msb_unused = diff[WIDTH];

  assign r_nxt = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign q_nxt = {q_q[WIDTH-2:0], ~borrow};

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DIV_DONE;
          end else begin
            q_d     = dividend;
            r_d     = '0;
            dvs_d   = divisor;
            dbz_d   = 1'b0;
            cnt_d   = CW'(WIDTH - 1);
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        q_d   = q_nxt;
        r_d   = r_nxt;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          cnt_d   = '0;
          quot_d  = q_nxt;
          rem_d   = r_nxt;
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != DIV_IDLE);
  assign done        = (state_q == DIV_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_division.sv
// Directed and random checks of the sequential divider at WIDTH=4.
module tb_division;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[8];

  division #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Start one division, measure latency counting the capture edge as edge 1.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ez, input string tag);
    int lat;
    int exp_lat;
    logic seen;
    exp_lat = (b == '0) ? 1 : W + 1;
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    lat  = 1;
    seen = done;
    if (!seen) begin
      chk({tag, " hold_q"}, int'(quotient), int'(last_q));
      chk({tag, " hold_r"}, int'(remainder), int'(last_r));
    end
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      seen = done;
    end
    chk({tag, " done_seen"}, int'(seen), 1);
    if (seen) begin
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " q"}, int'(quotient), int'(eq));
      chk({tag, " r"}, int'(remainder), int'(er));
      chk({tag, " dbz"}, int'(div_by_zero), int'(ez));
      chk({tag, " busy_in_done"}, int'(busy), 1);
      @(posedge clk); #1;
      chk({tag, " done_pulse"}, int'(done), 0);
      chk({tag, " idle"}, int'(busy), 0);
      chk({tag, " q_held"}, int'(quotient), int'(eq));
    end
    last_q = eq;
    last_r = er;
  endtask

  initial begin
    int lat;
    int first_lat;
    int n_done;
    logic [W-1:0] ra, rb, rq, rr;

    tbl[0] = '{a: 4'd13, b: 4'd4,  q: 4'd3,  r: 4'd1, z: 1'b0};
    tbl[1] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};
    tbl[2] = '{a: 4'd6,  b: 4'd3,  q: 4'd2,  r: 4'd0, z: 1'b0};
    tbl[3] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
    tbl[4] = '{a: 4'd0,  b: 4'd7,  q: 4'd0,  r: 4'd0, z: 1'b0};
    tbl[5] = '{a: 4'd3,  b: 4'd5,  q: 4'd0,  r: 4'd3, z: 1'b0};
    tbl[6] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
    tbl[7] = '{a: 4'd0,  b: 4'd0,  q: 4'd15, r: 4'd0, z: 1'b1};

    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst q", int'(quotient), 0);
    chk("rst r", int'(remainder), 0);
    chk("rst dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 8; i++)
      run_div(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, tbl[i].z, $sformatf("vec%0d", i));

    // Second start during CALC must be dropped, not queued.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1; n_done = 0; first_lat = 0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd8; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (lat < 14) begin
      if (done) begin
        n_done++;
        if (first_lat == 0) begin
          first_lat = lat;
          chk("ign q", int'(quotient), 4);
          chk("ign r", int'(remainder), 2);
        end
      end
      @(posedge clk); #1;
      lat++;
    end
    chk("ign done_count", n_done, 1);
    chk("ign latency", first_lat, W + 1);
    last_q = 4'd4; last_r = 4'd2;

    // Reset in the middle of a calculation aborts it without a done.
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort busy", int'(busy), 0);
    chk("abort done", int'(done), 0);
    chk("abort q", int'(quotient), 0);
    chk("abort r", int'(remainder), 0);
    chk("abort dbz", int'(div_by_zero), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    chk("abort quiet", n_done, 0);
    last_q = '0; last_r = '0;
    run_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "post_rst");

    for (int unsigned k = 0; k < 500; k++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (rb == '0) begin
        rq = '1;
        rr = ra;
      end else begin
        rq = ra / rb;
        rr = ra % rb;
      end
      run_div(ra, rb, rq, rr, (rb == '0), $sformatf("rnd%0d_%0d/%0d", k, ra, rb));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
